// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter with valid/ready input.
// Frame: start, DATA_BITS payload LSB first, optional parity, 1-2 stop bits.
module uart_tx_param #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx_out,
    output logic                 tx_done
);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
        $error("uart_tx_param: DATA_BITS must be 5..9");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_clks
        $error("uart_tx_param: CLKS_PER_BIT must be >= 2");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_par
        $error("uart_tx_param: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_param: STOP_BITS must be 1 or 2");
    end

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int CNT_W  = $clog2(DATA_BITS) + 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  DATA_LAST = CNT_W'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0]  STOP_LAST = CNT_W'(STOP_BITS - 1);
    localparam logic              ODD       = (PARITY == 2);
    localparam logic              HAS_PAR   = (PARITY != 0);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } state_t;

    state_t               state_q, state_d;
    logic [BAUD_W-1:0]    baud_q, baud_d;
    logic [CNT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] sh_q, sh_d;
    logic                 par_q, par_d;
    logic                 out_q, out_d;
    logic                 ready_q, ready_d;
    logic                 done_q, done_d;
    logic                 baud_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            par_q   <= 1'b0;
            out_q   <= 1'b1;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            par_q   <= par_d;
            out_q   <= out_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    assign baud_last = (baud_q == BAUD_LAST);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        par_d   = par_q;
        out_d   = out_q;
        ready_d = ready_q;
        done_d  = 1'b0;

        if (state_q != IDLE) begin
            baud_d = baud_last ? '0 : baud_q + 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                out_d   = 1'b1;
                ready_d = 1'b1;
                // Output is registered on the accept edge, so the start bit
                // appears on the line with zero added latency.
                if (tx_valid && ready_q) begin
                    sh_d    = tx_data;
                    par_d   = (^tx_data) ^ ODD;
                    state_d = START;
                    out_d   = 1'b0;
                    ready_d = 1'b0;
                    baud_d  = '0;
                end
            end
            START: begin
                if (baud_last) begin
                    state_d = DATA;
                    bit_d   = '0;
                    out_d   = sh_q[0];
                    sh_d    = sh_q >> 1;
                end
            end
            DATA: begin
                if (baud_last) begin
                    if (bit_q == DATA_LAST) begin
                        bit_d = '0;
                        if (HAS_PAR) begin
                            state_d = PAR;
                            out_d   = par_q;
                        end else begin
                            state_d = STOP;
                            out_d   = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + 1'b1;
                        out_d = sh_q[0];
                        sh_d  = sh_q >> 1;
                    end
                end
            end
            PAR: begin
                if (baud_last) begin
                    state_d = STOP;
                    bit_d   = '0;
                    out_d   = 1'b1;
                end
            end
            STOP: begin
                if (baud_last) begin
                    if (bit_q == STOP_LAST) begin
                        state_d = IDLE;
                        bit_d   = '0;
                        out_d   = 1'b1;
                        ready_d = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                out_d   = 1'b1;
                ready_d = 1'b1;
            end
        endcase
    end

    assign tx_out   = out_q;
    assign tx_ready = ready_q;
    assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: four transmitter configurations checked by line monitors
// against hand-computed frames queued at stimulus time.
module tb_uart_tx_param;

    typedef struct packed {
        logic       b2b;
        logic       par;
        logic [8:0] line;
    } exp_t;

    int NB[4] = '{8, 8, 8, 7};
    int PM[4] = '{0, 1, 2, 0};
    int SB[4] = '{1, 1, 1, 2};

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] vld;
    logic [8:0] data;
    wire  [3:0] rdy_w;
    wire  [3:0] out_w;
    wire  [3:0] done_w;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   dcnt[4] = '{default: 0};
    int   last_done[4] = '{default: 0};
    bit   mon_en = 1'b1;
    exp_t eq[4][$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk)
        for (int u = 0; u < 4; u++)
            if (done_w[u] === 1'b1) dcnt[u] <= dcnt[u] + 1;

    uart_tx_param #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1)) u_a (
        .clk(clk), .reset(reset), .tx_valid(vld[0]), .tx_data(data[7:0]),
        .tx_ready(rdy_w[0]), .tx_out(out_w[0]), .tx_done(done_w[0]));
    uart_tx_param #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(1)) u_b (
        .clk(clk), .reset(reset), .tx_valid(vld[1]), .tx_data(data[7:0]),
        .tx_ready(rdy_w[1]), .tx_out(out_w[1]), .tx_done(done_w[1]));
    uart_tx_param #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(1)) u_c (
        .clk(clk), .reset(reset), .tx_valid(vld[2]), .tx_data(data[7:0]),
        .tx_ready(rdy_w[2]), .tx_out(out_w[2]), .tx_done(done_w[2]));
    uart_tx_param #(.DATA_BITS(7), .CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(2)) u_d (
        .clk(clk), .reset(reset), .tx_valid(vld[3]), .tx_data(data[6:0]),
        .tx_ready(rdy_w[3]), .tx_out(out_w[3]), .tx_done(done_w[3]));

    function automatic int flen(input int u);
        return (1 + NB[u] + ((PM[u] != 0) ? 1 : 0) + SB[u]) * 4;
    endfunction

    task automatic chk(input int u, input logic [31:0] act,
                       input logic [31:0] exp, input string nm);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s unit%0d: got %0h want %0h (cycle %0d)",
                     nm, u, act, exp, cyc);
        end
    endtask

    task automatic push(input int u, input logic b2b, input logic par,
                        input logic [8:0] line);
        exp_t e;
        e.b2b  = b2b;
        e.par  = par;
        e.line = line;
        eq[u].push_back(e);
    endtask

    task automatic send(input logic [3:0] m, input logic [8:0] d);
        @(negedge clk);
        for (int u = 0; u < 4; u++)
            if (m[u]) chk(u, 32'(rdy_w[u]), 32'd1, "ready_before_send");
        data = d;
        vld  = vld | m;
        @(posedge clk);
        #1 vld = vld & ~m;
    endtask

    task automatic monitor(input int u);
        exp_t e;
        int   n0;
        bit   have;
        have = 1'b0;
        forever begin
            if (!have) @(negedge clk);
            have = 1'b0;
            if (mon_en && out_w[u] === 1'b0) begin
                n0 = cyc;
                if (eq[u].size() == 0) begin
                    chk(u, 32'(eq[u].size()), 32'd1, "unexpected_frame");
                    repeat (flen(u)) @(negedge clk);
                end else begin
                    e = eq[u].pop_front();
                    if (e.b2b) chk(u, 32'(n0), 32'(last_done[u] + 1), "b2b_gap");
                    repeat (2) @(negedge clk);
                    chk(u, 32'(out_w[u]), 32'd0, "start_bit");
                    chk(u, 32'(rdy_w[u]), 32'd0, "ready_busy");
                    for (int i = 0; i < NB[u]; i++) begin
                        repeat (4) @(negedge clk);
                        chk(u, 32'(out_w[u]), 32'(e.line[i]), "data_bit");
                    end
                    if (PM[u] != 0) begin
                        repeat (4) @(negedge clk);
                        chk(u, 32'(out_w[u]), 32'(e.par), "parity_bit");
                    end
                    for (int s = 0; s < SB[u]; s++) begin
                        repeat (4) @(negedge clk);
                        chk(u, 32'(out_w[u]), 32'd1, "stop_bit");
                    end
                    @(negedge clk);
                    chk(u, 32'(done_w[u]), 32'd0, "done_early");
                    chk(u, 32'(rdy_w[u]), 32'd0, "ready_last");
                    @(negedge clk);
                    chk(u, 32'(done_w[u]), 32'd1, "done_pulse");
                    chk(u, 32'(rdy_w[u]), 32'd1, "ready_at_done");
                    chk(u, 32'(out_w[u]), 32'd1, "line_at_done");
                    chk(u, 32'(cyc - n0), 32'(flen(u)), "frame_len");
                    last_done[u] = cyc;
                    @(negedge clk);
                    chk(u, 32'(done_w[u]), 32'd0, "done_width");
                    have = 1'b1;
                end
            end
        end
    endtask

    initial begin
        int  d0;
        int  d1;
        bit  got;
        reset = 1'b1;
        vld   = 4'b0000;
        data  = 9'h000;
        fork
            monitor(0);
            monitor(1);
            monitor(2);
            monitor(3);
        join_none
        repeat (2) @(posedge clk);
        #1;
        for (int u = 0; u < 4; u++) begin
            chk(u, 32'(out_w[u]), 32'd1, "reset_out");
            chk(u, 32'(rdy_w[u]), 32'd1, "reset_ready");
            chk(u, 32'(done_w[u]), 32'd0, "reset_done");
        end
        reset = 1'b0;
        repeat (2) @(posedge clk);

        push(0, 1'b0, 1'b0, 9'h0AA);
        send(4'b0001, 9'h0AA);
        repeat (50) @(posedge clk);

        push(1, 1'b0, 1'b1, 9'h007);
        push(2, 1'b0, 1'b0, 9'h007);
        send(4'b0110, 9'h007);
        repeat (55) @(posedge clk);

        push(3, 1'b0, 1'b0, 9'h055);
        send(4'b1000, 9'h0D5);
        repeat (50) @(posedge clk);

        d0 = dcnt[0];
        push(0, 1'b0, 1'b0, 9'h001);
        push(0, 1'b1, 1'b0, 9'h080);
        #1 data = 9'h001;
        vld[0] = 1'b1;
        @(posedge clk);
        got = 1'b0;
        for (int n = 0; n < 100 && !got; n++) begin
            @(posedge clk);
            #1 if (done_w[0]) got = 1'b1;
        end
        chk(0, 32'(got), 32'd1, "b2b_done_seen");
        data = 9'h080;
        @(posedge clk);
        #1 vld[0] = 1'b0;
        chk(0, 32'(rdy_w[0]), 32'd0, "b2b_accept");
        repeat (60) @(posedge clk);
        chk(0, 32'(dcnt[0] - d0), 32'd2, "b2b_done_count");

        mon_en = 1'b0;
        d0 = dcnt[0];
        send(4'b0001, 9'h03C);
        repeat (12) @(posedge clk);
        #1 reset = 1'b1;
        vld[0] = 1'b1;
        @(posedge clk);
        #1 chk(0, 32'(out_w[0]), 32'd1, "abort_out");
        chk(0, 32'(rdy_w[0]), 32'd1, "abort_ready");
        chk(0, 32'(done_w[0]), 32'd0, "abort_done");
        @(posedge clk);
        #1 chk(0, 32'(out_w[0]), 32'd1, "valid_in_reset");
        reset = 1'b0;
        vld[0] = 1'b0;
        repeat (60) @(posedge clk);
        chk(0, 32'(dcnt[0] - d0), 32'd0, "abort_no_done");
        mon_en = 1'b1;
        push(0, 1'b0, 1'b0, 9'h03C);
        send(4'b0001, 9'h03C);
        repeat (50) @(posedge clk);

        d1 = dcnt[1];
        push(1, 1'b0, 1'b0, 9'h05A);
        send(4'b0010, 9'h05A);
        for (int i = 0; i < 35; i++) begin
            @(posedge clk);
            #1 vld[1] = 1'($urandom_range(0, 1));
            data = 9'($urandom_range(0, 511));
        end
        vld[1] = 1'b0;
        repeat (60) @(posedge clk);
        chk(1, 32'(dcnt[1] - d1), 32'd1, "busy_single_frame");

        for (int u = 0; u < 4; u++)
            chk(u, 32'(eq[u].size()), 32'd0, "frames_outstanding");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
